// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction fetch queue:
//   NOP_INSTR     - instruction presented on id_instr when nothing is valid
//   PC_INC        - fetch address step per accepted request
//   fetch_state_t - fetch FSM states (RUN issues requests, DRAIN discards
//                   responses that belong to a squashed fetch stream)
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous circular FIFO, DEPTH entries of W bits, with occupancy count.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, wdata     - write request / data (ignored when full unless a pop
//                     frees a slot in the same cycle)
//   pop             - remove head entry (ignored when empty)
//   flush           - drop all contents; wins over push and pop
//   rdata           - head entry (valid when empty = 0)
//   count           - number of stored entries, 0..DEPTH
//   full, empty     - occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end: issues sequential word fetches to instruction
// memory, tracks the PC of every in-flight request, queues returned
// instructions for decode and squashes the stream on a redirect.
//
// Handshakes: every channel uses strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; a source holding valid may
// not depend on ready, and payload is only meaningful while valid is high.
// The response channel has no ready: the memory returns responses in request
// order, at least one cycle after acceptance, and they are always taken.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   imem_req_valid/addr/ready     - fetch request channel
//   imem_rsp_valid/data           - in-order fetch responses
//   id_valid/instr/pc/ready       - queue head to decode (instr = NOP when
//                                   id_valid is low, pc = 0 then)
//   redirect, redirect_pc         - taken branch/jump: flush and refetch
//   dbg_state                     - current fetch FSM state
//
// Parameters: XLEN (PC width), DEPTH (queue entries = max in-flight requests,
// power of two >= 2), RESET_PC (first fetch address).
//
// Configuration macro FETCH_QUEUE_BYPASS_EN: when defined, a live response
// arriving while the queue is empty is presented on id_* in the same cycle
// and is only written to the queue if decode does not take it. When
// undefined, every response goes through queue storage (one cycle latency).
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output fetch_state_t    dbg_state
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = XLEN + 32;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   drop_cnt;

  logic [CW-1:0]   trk_count;
  logic            trk_full;
  logic            trk_empty;
  logic [XLEN-1:0] trk_pc;

  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   q_rdata;
  logic [EW-1:0]   q_wdata;
  logic            q_push;
  logic            q_pop;

  logic [CW-1:0]   inflight;
  logic [CW:0]     occupancy;
  logic            credit_ok;
  logic            req_hs;
  logic            rsp_seen;
  logic            rsp_live;
  logic            rsp_drop;
  logic [CW:0]     redir_inflight;
  logic [CW-1:0]   redir_drop;
  logic [CW-1:0]   drain_next;
  logic            head_valid;
  logic [EW-1:0]   head_data;

  // In RUN every outstanding request has a tracked PC; in DRAIN the tracker is
  // flushed and the outstanding (stale) requests are counted by drop_cnt.
  assign inflight  = (state == RUN) ? trk_count : drop_cnt;
  assign occupancy = {1'b0, q_count} + {1'b0, inflight};
  // Credit rule: a queue slot is reserved for every outstanding request, so
  // the queue can never overflow however long decode stalls.
  assign credit_ok = (occupancy < CW1'(DEPTH));

  assign imem_req_valid = !rst && (state == RUN) && credit_ok && !q_full && !trk_full;
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign rsp_seen = imem_rsp_valid && !trk_empty;
  // A response in the redirect cycle belongs to the squashed stream.
  assign rsp_live = rsp_seen && (state == RUN) && !redirect;
  assign rsp_drop = imem_rsp_valid && (state == DRAIN) && (drop_cnt != '0);

  // Outstanding count after this edge if the stream is squashed now: tracked
  // requests plus this cycle's acceptance, minus a response arriving now.
  assign redir_inflight = {1'b0, trk_count} + CW1'(req_hs);
  assign redir_drop     = trk_count + CW'(req_hs) - CW'(rsp_seen);
  assign drain_next     = drop_cnt - CW'(rsp_drop);

  assign q_wdata = {trk_pc, imem_rsp_data};
  assign q_pop   = id_ready && !q_empty;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass     = rsp_live && q_empty;
    q_push     = rsp_live && !(bypass && id_ready);
    head_valid = !q_empty || bypass;
    head_data  = q_empty ? q_wdata : q_rdata;
  end
`else
  always_comb begin
    q_push     = rsp_live;
    head_valid = !q_empty;
    head_data  = q_rdata;
  end
`endif

  assign id_valid  = head_valid;
  assign id_instr  = head_valid ? head_data[31:0] : NOP_INSTR;
  assign id_pc     = head_valid ? head_data[EW-1:32] : '0;
  assign dbg_state = state;

  // PCs of accepted requests in order; the head matches the next response.
  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_track (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs),
    .wdata (fetch_pc),
    .pop   (rsp_live),
    .flush (redirect),
    .rdata (trk_pc),
    .count (trk_count),
    .full  (trk_full),
    .empty (trk_empty)
  );

  // Instruction queue of {pc, instr}; redirect flush wins over a dequeue.
  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .flush (redirect),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      drop_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            target_pc <= redirect_pc;
            if (redir_inflight != '0) begin
              state    <= DRAIN;
              drop_cnt <= redir_drop;
            end else begin
              fetch_pc <= redirect_pc;
            end
          end else if (req_hs) begin
            fetch_pc <= fetch_pc + XLEN'(PC_INC);
          end
        end
        DRAIN: begin
          drop_cnt <= drain_next;
          // A further redirect only retargets; draining continues, and the
          // FSM leaves once the count is zero in a cycle without redirect.
          if (redirect) begin
            target_pc <= redirect_pc;
          end else if (drain_next == '0) begin
            state    <= RUN;
            fetch_pc <= target_pc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
